// File: rtl/trng_ctrl_pkg.sv
// Shared types and helpers for the TRNG access controller.
// The state enum and the counter-width helper are used by the controller and its bench.
package trng_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RING_RST,
    ST_WARMUP,
    ST_RUN,
    ST_FAIL
  } state_e;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping.
// The pointer register is owned by the parent.
module trng_rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/trng_access_ctrl.sv
// Sequences one ring-oscillator TRNG (ring reset, warm-up, health tests) and hands
// its fresh bytes round-robin to NREQ requesters.
module trng_access_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NREQ         = 4,
  parameter int RST_CYCLES   = 16,
  parameter int WARMUP_READS = 4,
  parameter int REP_LIMIT    = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_restart,
  output logic             o_trng_reset,
  output logic             o_trng_read,
  input  logic [WIDTH-1:0] i_trng_dat,
  input  logic             i_trng_valid,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_gnt,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_dat_valid,
  output logic             o_ready,
  output logic             o_fail
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RST_W   = cnt_w(RST_CYCLES);
  localparam int WARM_W  = cnt_w(WARMUP_READS);
  localparam int REP_W   = cnt_w(REP_LIMIT);
  localparam int STALL_W = cnt_w(TIMEOUT);

  state_e             state, state_nxt;
  logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_nxt;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_nxt, rep_calc;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
  logic [WIDTH-1:0]   last_dat, last_dat_nxt;
  logic [IDX_W-1:0]   ptr;
  logic               deliver;

  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  trng_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign o_ready = (state == ST_RUN);
  assign o_fail  = (state == ST_FAIL);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = rst_cnt;
    warm_cnt_nxt  = warm_cnt;
    rep_cnt_nxt   = rep_cnt;
    stall_cnt_nxt = stall_cnt;
    last_dat_nxt  = last_dat;
    o_trng_reset  = 1'b0;
    o_trng_read   = 1'b0;
    deliver       = 1'b0;
    // rep_cnt == 0 means no byte has been read since the last (re)start.
    rep_calc = (rep_cnt != '0 && i_trng_dat == last_dat) ? rep_cnt + REP_W'(1) : REP_W'(1);

    case (state)
      ST_RING_RST: begin
        o_trng_reset = 1'b1;
        if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
          rst_cnt_nxt = '0;
          state_nxt   = ST_WARMUP;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end

      ST_WARMUP, ST_RUN: begin
        o_trng_read = (state == ST_WARMUP) ? i_trng_valid : (i_trng_valid & arb_any);

        if (i_trng_valid) begin
          stall_cnt_nxt = '0;
        end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
          state_nxt = ST_FAIL;
        end else begin
          stall_cnt_nxt = stall_cnt + STALL_W'(1);
        end

        if (o_trng_read) begin
          last_dat_nxt = i_trng_dat;
          rep_cnt_nxt  = rep_calc;
          if (rep_calc == REP_W'(REP_LIMIT)) begin
            state_nxt = ST_FAIL;
          end else if (state == ST_WARMUP) begin
            warm_cnt_nxt = warm_cnt + WARM_W'(1);
            if (warm_cnt == WARM_W'(WARMUP_READS - 1)) state_nxt = ST_RUN;
          end else begin
            deliver = 1'b1;
          end
        end
      end

      ST_FAIL: o_trng_reset = 1'b1;

      default: state_nxt = ST_RING_RST;
    endcase

    if (i_restart) begin
      state_nxt     = ST_RING_RST;
      rst_cnt_nxt   = '0;
      warm_cnt_nxt  = '0;
      rep_cnt_nxt   = '0;
      stall_cnt_nxt = '0;
      last_dat_nxt  = '0;
      deliver       = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_RING_RST;
      rst_cnt     <= '0;
      warm_cnt    <= '0;
      rep_cnt     <= '0;
      stall_cnt   <= '0;
      last_dat    <= '0;
      ptr         <= '0;
      o_gnt       <= '0;
      o_dat       <= '0;
      o_dat_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      warm_cnt    <= warm_cnt_nxt;
      rep_cnt     <= rep_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
      last_dat    <= last_dat_nxt;
      o_dat_valid <= deliver;
      o_gnt       <= deliver ? arb_gnt : '0;
      if (deliver) begin
        o_dat <= i_trng_dat;
        if (arb_idx == IDX_W'(NREQ - 1)) ptr <= '0;
        else                             ptr <= arb_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trng_access_ctrl.sv
// Self-checking bench for trng_access_ctrl: a vector table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_trng_access_ctrl;

  localparam int WIDTH        = 8;
  localparam int NREQ         = 4;
  localparam int RST_CYCLES   = 16;
  localparam int WARMUP_READS = 4;
  localparam int REP_LIMIT    = 4;
  localparam int TIMEOUT      = 64;

  localparam int PH_RING = 0, PH_WARM = 1, PH_RUN = 2, PH_FAIL = 3;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_restart = 1'b0;
  logic             o_trng_reset, o_trng_read;
  logic [WIDTH-1:0] i_trng_dat = '0;
  logic             i_trng_valid = 1'b0;
  logic [NREQ-1:0]  i_req = '0;
  logic [NREQ-1:0]  o_gnt;
  logic [WIDTH-1:0] o_dat;
  logic             o_dat_valid, o_ready, o_fail;

  always #5 i_clk = ~i_clk;

  trng_access_ctrl #(
    .WIDTH(WIDTH), .NREQ(NREQ), .RST_CYCLES(RST_CYCLES),
    .WARMUP_READS(WARMUP_READS), .REP_LIMIT(REP_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_restart(i_restart),
    .o_trng_reset(o_trng_reset), .o_trng_read(o_trng_read),
    .i_trng_dat(i_trng_dat), .i_trng_valid(i_trng_valid),
    .i_req(i_req), .o_gnt(o_gnt), .o_dat(o_dat), .o_dat_valid(o_dat_valid),
    .o_ready(o_ready), .o_fail(o_fail)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase, remaining-work counters and a short byte history.
  bit               m_known = 0;
  int               m_phase, m_rst_left, m_warm_left, m_idle, m_ptr;
  logic [WIDTH-1:0] m_hist[$];
  logic [NREQ-1:0]  m_gnt;
  logic             m_dv;
  logic [WIDTH-1:0] m_dat;

  // Values seen on the most recent step.
  logic             obs_trng_reset, obs_read, obs_ready, obs_fail, obs_dv;
  logic [NREQ-1:0]  obs_gnt;
  logic [WIDTH-1:0] obs_dat;

  logic [WIDTH-1:0] seed_b = 8'h01;

  typedef struct {
    logic [NREQ-1:0]  req;
    logic             valid;
    logic [WIDTH-1:0] dat;
    logic             exp_read;
    logic [NREQ-1:0]  exp_gnt;
    logic             exp_dv;
    logic [WIDTH-1:0] exp_dat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_restart();
    m_phase     = PH_RING;
    m_rst_left  = RST_CYCLES;
    m_warm_left = WARMUP_READS;
    m_idle      = 0;
    m_hist.delete();
  endtask

  function automatic int trailing_run();
    int n = 0;
    int i = m_hist.size() - 1;
    while (i >= 0 && m_hist[i] == m_hist[m_hist.size() - 1]) begin
      n++;
      i--;
    end
    return n;
  endfunction

  task automatic step(input logic rst, input logic rs, input logic [NREQ-1:0] req,
                      input logic vld, input logic [WIDTH-1:0] dat);
    logic exp_read;
    bit   found;
    @(negedge i_clk);
    i_reset = rst; i_restart = rs; i_req = req; i_trng_valid = vld; i_trng_dat = dat;
    #1;
    obs_trng_reset = o_trng_reset; obs_read = o_trng_read; obs_ready = o_ready;
    obs_fail = o_fail; obs_dv = o_dat_valid; obs_gnt = o_gnt; obs_dat = o_dat;
    exp_read = (m_phase == PH_WARM && vld) || (m_phase == PH_RUN && vld && req != '0);
    if (m_known) begin
      check("trng_reset", 32'(obs_trng_reset), 32'(m_phase == PH_RING || m_phase == PH_FAIL));
      check("trng_read",  32'(obs_read),  32'(exp_read));
      check("ready",      32'(obs_ready), 32'(m_phase == PH_RUN));
      check("fail",       32'(obs_fail),  32'(m_phase == PH_FAIL));
      check("gnt",        32'(obs_gnt),   32'(m_gnt));
      check("dat_valid",  32'(obs_dv),    32'(m_dv));
      check("dat",        32'(obs_dat),   32'(m_dat));
    end
    @(posedge i_clk);
    if (rst) begin
      model_restart();
      m_ptr = 0; m_gnt = '0; m_dv = 1'b0; m_dat = '0; m_known = 1;
    end else if (m_known) begin
      m_gnt = '0;
      m_dv  = 1'b0;
      if (rs) model_restart();
      else if (m_phase == PH_RING) begin
        m_rst_left--;
        if (m_rst_left == 0) m_phase = PH_WARM;
      end else if (m_phase == PH_WARM || m_phase == PH_RUN) begin
        if (!vld) begin
          m_idle++;
          if (m_idle >= TIMEOUT) m_phase = PH_FAIL;
        end else begin
          m_idle = 0;
          if (exp_read) begin
            m_hist.push_back(dat);
            if (m_hist.size() > REP_LIMIT) void'(m_hist.pop_front());
            if (trailing_run() >= REP_LIMIT) m_phase = PH_FAIL;
            else if (m_phase == PH_WARM) begin
              m_warm_left--;
              if (m_warm_left == 0) m_phase = PH_RUN;
            end else begin
              found = 0;
              for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (!found && req[i]) begin
                  found = 1;
                  m_gnt = NREQ'(1) << i;
                  m_dv  = 1'b1;
                  m_dat = dat;
                  m_ptr = (i + 1) % NREQ;
                end
              end
            end
          end
        end
      end
    end
  endtask

  int rst_hi, reads, dvs;
  logic first_fail, first_dv, first_ready;
  logic [WIDTH-1:0] first_dat;

  // Idle requesters, TRNG always valid with distinct bytes, until RUN is seen.
  task automatic startup();
    rst_hi = 0; reads = 0; dvs = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, '0, 1'b1, seed_b);
      seed_b = seed_b + 8'd1;
      if (i == 0) begin
        first_fail = obs_fail; first_dv = obs_dv; first_ready = obs_ready; first_dat = obs_dat;
      end
      if (obs_trng_reset) rst_hi++;
      if (obs_read) reads++;
      if (obs_dv) dvs++;
      if (obs_ready) break;
    end
    check("startup_rst_cycles", 32'(rst_hi), 32'(RST_CYCLES));
    check("startup_reads", 32'(reads), 32'(WARMUP_READS));
    check("startup_no_delivery", 32'(dvs), 32'd0);
    check("startup_ready", 32'(obs_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'hF, 1'b1, 8'h11, 1'b1, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{4'hF, 1'b1, 8'h22, 1'b1, 4'b0001, 1'b1, 8'h11};
    tbl[2] = '{4'hF, 1'b1, 8'h33, 1'b1, 4'b0010, 1'b1, 8'h22};
    tbl[3] = '{4'hF, 1'b1, 8'h44, 1'b1, 4'b0100, 1'b1, 8'h33};
    tbl[4] = '{4'hF, 1'b1, 8'h55, 1'b1, 4'b1000, 1'b1, 8'h44};
    tbl[5] = '{4'h0, 1'b1, 8'h66, 1'b0, 4'b0001, 1'b1, 8'h55};
    tbl[6] = '{4'h9, 1'b1, 8'h77, 1'b1, 4'b0000, 1'b0, 8'h55};
    tbl[7] = '{4'h9, 1'b1, 8'h88, 1'b1, 4'b1000, 1'b1, 8'h77};
    tbl[8] = '{4'h0, 1'b1, 8'h99, 1'b0, 4'b0001, 1'b1, 8'h88};

    step(1, 0, '0, 1'b0, '0);
    step(1, 0, '0, 1'b0, '0);
    startup();

    // Round robin over all requesters, then skipping idle ones from pointer 1.
    for (int i = 0; i < 9; i++) begin
      step(0, 0, tbl[i].req, tbl[i].valid, tbl[i].dat);
      check("tbl_read", 32'(obs_read), 32'(tbl[i].exp_read));
      check("tbl_gnt", 32'(obs_gnt), 32'(tbl[i].exp_gnt));
      check("tbl_dv", 32'(obs_dv), 32'(tbl[i].exp_dv));
      check("tbl_dat", 32'(obs_dat), 32'(tbl[i].exp_dat));
    end

    // Four identical bytes: three delivered, the fourth trips the health test.
    dvs = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'hF, 1'b1, 8'hA5);
      if (obs_dv) dvs++;
    end
    step(0, 0, 4'h0, 1'b1, 8'h5A);
    if (obs_dv) dvs++;
    check("rep_delivered", 32'(dvs), 32'd3);
    check("rep_fail", 32'(obs_fail), 32'd1);
    check("rep_trng_reset", 32'(obs_trng_reset), 32'd1);
    check("rep_last_dat", 32'(obs_dat), 32'hA5);
    step(0, 1, 4'h0, 1'b1, 8'h00);
    startup();
    check("restart_clears_fail", 32'(first_fail), 32'd0);

    // Watchdog: 63 idle cycles survive, 64 trip it.
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 4'h0, 1'b0, 8'h00);
    step(0, 0, 4'h0, 1'b1, 8'h00);
    step(0, 0, 4'h0, 1'b1, 8'h00);
    check("wd_63_ready", 32'(obs_ready), 32'd1);
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 4'h0, 1'b0, 8'h00);
    check("wd_64_still_run", 32'(obs_ready), 32'd1);
    step(0, 0, 4'h0, 1'b0, 8'h00);
    check("wd_fail", 32'(obs_fail), 32'd1);

    // Reset while failed returns every output to its reset value.
    step(1, 0, 4'hF, 1'b1, 8'h00);
    startup();
    check("rst_fail_clr", 32'(first_fail), 32'd0);
    check("rst_dv_clr", 32'(first_dv), 32'd0);
    check("rst_ready_clr", 32'(first_ready), 32'd0);
    check("rst_dat_clr", 32'(first_dat), 32'd0);

    // Restart on the same cycle as a read: byte consumed, nothing delivered.
    step(0, 1, 4'hF, 1'b1, 8'h3C);
    check("restart_read", 32'(obs_read), 32'd1);
    startup();
    check("restart_no_dv", 32'(first_dv), 32'd0);

    // Randomized traffic against the model.
    begin
      bit narrow = 0;
      int burst = 0;
      step(1, 0, '0, 1'b0, '0);
      for (int n = 0; n < 6000; n++) begin
        logic rst, rs, vld;
        logic [WIDTH-1:0] d;
        if (n % 700 == 0) narrow = ~narrow;
        if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(60, 70);
        rst = ($urandom_range(0, 599) == 0);
        rs  = ($urandom_range(0, 79) == 0);
        if (burst > 0) begin
          vld = 1'b0;
          burst--;
        end else begin
          vld = ($urandom_range(0, 7) != 0);
        end
        d = narrow ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom);
        step(rst, rs, NREQ'($urandom), vld, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trng_access_ctrl.md
Name: trng_access_ctrl

Overview:
Controller that sequences one async-ring TRNG instance (byte-wide output, o_valid/i_read handshake) and shares its output among NREQ requesters.
- Ring reset and warm-up: holds the rings in reset, then discards the first samples.
- Arbitration: round-robin grants of fresh bytes to requesters.
- Health tests: repetition-count test and a stall watchdog; enters a sticky FAIL state on violation.
- Placement: between the TRNG and the consumer bus.

Parameters:
WIDTH, 8, TRNG output byte width.
NREQ, 4, number of requesters (>=2).
RST_CYCLES, 16, cycles o_trng_reset is held high on every (re)start.
WARMUP_READS, 4, TRNG bytes read and discarded before RUN.
REP_LIMIT, 4, consecutive identical bytes that trigger FAIL (>=2).
TIMEOUT, 64, max consecutive cycles in WARMUP/RUN with i_trng_valid low (must exceed WIDTH).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_restart  in  1  single-cycle pulse: restart the sequence from RING_RST; also clears FAIL
o_trng_reset  out  1  drives the TRNG i_reset
o_trng_read  out  1  drives the TRNG i_read (combinational)
i_trng_dat  in  WIDTH  TRNG o_dat
i_trng_valid  in  1  TRNG o_valid
i_req  in  NREQ  level requests, one bit per requester
o_gnt  out  NREQ  one-hot grant, 1-cycle pulse, aligned with o_dat_valid
o_dat  out  WIDTH  delivered byte, holds its value until the next delivery
o_dat_valid  out  1  1-cycle pulse
o_ready  out  1  high in RUN
o_fail  out  1  high in FAIL

Behaviour:
Reset and priority
- Reset (priority over everything): state=RING_RST; all counters 0; rr pointer 0; o_gnt=0, o_dat=0, o_dat_valid=0, o_ready=0, o_fail=0.
- i_restart (priority below reset, above all other events, any state): next state RING_RST, all counters and the last-byte register cleared.

States
- RING_RST
  - o_trng_reset=1.
  - After RST_CYCLES cycles go to WARMUP.
- WARMUP
  - o_trng_reset=0.
  - o_trng_read = i_trng_valid.
  - Each read increments the warm-up count and updates the health state; nothing is delivered.
  - After the WARMUP_READS-th read go to RUN.
- RUN
  - o_ready=1.
  - o_trng_read = i_trng_valid & |i_req. With no requests the TRNG is not read and keeps accumulating.
  - On a read, the grant goes to the first requester at or after the rr pointer (wrapping).
  - Next cycle: o_gnt one-hot for that requester, o_dat = byte sampled on the read cycle, o_dat_valid=1.
  - Latency: 1 cycle from read to delivery.
  - The rr pointer moves to granted+1 mod NREQ.
  - Back-to-back grants are bounded by the TRNG refill (WIDTH cycles).
- FAIL
  - o_fail=1, o_trng_reset=1, o_trng_read=0, o_ready=0.
  - Sticky until i_restart or i_reset.

Repetition-count health test (WARMUP and RUN)
- On every read, compare i_trng_dat with the last read byte.
  - Equal: rep_cnt+1.
  - Different: rep_cnt=1.
- Update the last-byte register.
- If rep_cnt reaches REP_LIMIT, go to FAIL. The offending byte is consumed but not delivered: no o_dat_valid, no o_gnt that cycle.
- The first read after RING_RST sets rep_cnt=1.

Stall watchdog (WARMUP and RUN)
- Cycles with i_trng_valid=0 increment stall_cnt; i_trng_valid=1 clears it.
- stall_cnt==TIMEOUT goes to FAIL.
- Requests pending while valid is high do not count as a stall.

Other rules
- Counter widths use $clog2(max+1).
- Entering FAIL or RING_RST from RUN forces o_ready low next cycle.
- An in-flight delivery registered on the transition cycle still completes.

Decomposition:
- Shared package trng_ctrl_pkg: state enum (RING_RST, WARMUP, RUN, FAIL) and the counter-width helper function.
- Sub-module trng_rr_arbiter (NREQ): combinational round-robin pick from req and pointer. Outputs a one-hot grant and its index; the pointer register stays in the parent.

Test Plan:
- Startup: reset, hold i_req=0 -> o_trng_reset high 16 cycles; 4 reads discarded; then o_ready=1; no o_dat_valid.
- Round robin: i_req=4'b1111, distinct bytes 0x11,0x22,0x33,0x44,0x55 -> o_gnt 0001,0010,0100,1000,0001; each o_dat equals its byte, 1 cycle after o_trng_read.
- Skip idle requester: pointer at 1, i_req=4'b1001 -> grant 1000, then 0001.
- Repetition: four consecutive 0xA5 reads -> first three delivered, fourth not; o_fail=1, o_trng_reset=1; i_restart -> RING_RST and o_fail=0.
- Watchdog: in RUN hold i_trng_valid=0 for 64 cycles -> FAIL; 63 cycles then a valid cycle -> stays RUN.
- Restart/reset mid-op: i_restart while a read is pending -> RING_RST, counters cleared; i_reset asserted in FAIL -> all outputs at reset values next cycle.
